// File: rtl/uart_tx_serializer.sv
// UART transmit frame engine (start, 8 data LSB first, optional parity, stop) timed by the receive prescale.
// Optional feature: define UART_TX_HOLD_BUF_EN for a one-entry holding register enabling back-to-back frames.
module uart_tx_serializer (
  input  logic       clk_RX,
  input  logic       rst,
  input  logic [7:0] P_DATA,
  input  logic       data_valid,
  output logic       tx_ready,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  input  logic [5:0] prescale,
  output logic       TX_OUT,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t     state_q;
  logic [5:0] cnt_q;
  logic [5:0] pre_q;
  logic [2:0] bit_q;
  logic [7:0] shift_q;
  logic       par_q;
  logic       par_en_q;
  logic       tx_out_q;
  logic       busy_q;

  logic       bit_end_d;
  logic       accept_d;
  logic       idle_load_d;
  logic       stop_load_d;
  logic [7:0] src_data_d;
  logic       src_par_en_d;
  logic       src_par_typ_d;
  logic [5:0] src_pre_d;

  function automatic logic parity_f(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  function automatic logic [5:0] clamp_f(input logic [5:0] p);
    return (p < 6'd4) ? 6'd4 : p;
  endfunction

  assign bit_end_d = (cnt_q == (pre_q - 6'd1));
  assign TX_OUT    = tx_out_q;
  assign busy      = busy_q;

`ifdef UART_TX_HOLD_BUF_EN
  logic       hb_full_q;
  logic [7:0] hb_data_q;
  logic       hb_par_en_q;
  logic       hb_par_typ_q;
  logic [5:0] hb_pre_q;

  assign tx_ready      = !hb_full_q;
  assign accept_d      = data_valid && !hb_full_q;
  // A full buffer always wins over the live inputs so frame order is kept.
  assign idle_load_d   = hb_full_q || accept_d;
  assign stop_load_d   = hb_full_q;
  assign src_data_d    = hb_full_q ? hb_data_q    : P_DATA;
  assign src_par_en_d  = hb_full_q ? hb_par_en_q  : PAR_EN;
  assign src_par_typ_d = hb_full_q ? hb_par_typ_q : PAR_TYP;
  assign src_pre_d     = hb_full_q ? hb_pre_q     : clamp_f(prescale);

  // Holding register: filled by accepts outside IDLE, drained when the FSM loads from it.
  always_ff @(posedge clk_RX or negedge rst) begin
    if (!rst) begin
      hb_full_q    <= 1'b0;
      hb_data_q    <= 8'h00;
      hb_par_en_q  <= 1'b0;
      hb_par_typ_q <= 1'b0;
      hb_pre_q     <= 6'd0;
    end else if (accept_d && (state_q != IDLE)) begin
      hb_full_q    <= 1'b1;
      hb_data_q    <= P_DATA;
      hb_par_en_q  <= PAR_EN;
      hb_par_typ_q <= PAR_TYP;
      hb_pre_q     <= clamp_f(prescale);
    end else if (hb_full_q && ((state_q == IDLE) || ((state_q == STOP) && bit_end_d))) begin
      hb_full_q    <= 1'b0;
    end else begin
      hb_full_q    <= hb_full_q;
    end
  end
`else
  assign tx_ready      = (state_q == IDLE);
  assign accept_d      = data_valid && (state_q == IDLE);
  assign idle_load_d   = accept_d;
  assign stop_load_d   = 1'b0;
  assign src_data_d    = P_DATA;
  assign src_par_en_d  = PAR_EN;
  assign src_par_typ_d = PAR_TYP;
  assign src_pre_d     = clamp_f(prescale);
`endif

  // Frame FSM with bit timer, bit counter and registered line/busy outputs.
  always_ff @(posedge clk_RX or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      pre_q    <= 6'd0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      tx_out_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      if ((state_q == IDLE) || bit_end_d) begin
        cnt_q <= 6'd0;
      end else begin
        cnt_q <= cnt_q + 6'd1;
      end
      case (state_q)
        IDLE: begin
          if (idle_load_d) begin
            state_q  <= START;
            tx_out_q <= 1'b0;
            busy_q   <= 1'b1;
            shift_q  <= src_data_d;
            par_q    <= parity_f(src_data_d, src_par_typ_d);
            par_en_q <= src_par_en_d;
            pre_q    <= src_pre_d;
          end else begin
            tx_out_q <= 1'b1;
            busy_q   <= 1'b0;
          end
        end
        START: begin
          if (bit_end_d) begin
            state_q  <= DATA;
            tx_out_q <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_end_d) begin
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_q == 3'd7) begin
              bit_q <= 3'd0;
              if (par_en_q) begin
                state_q  <= PARITY;
                tx_out_q <= par_q;
              end else begin
                state_q  <= STOP;
                tx_out_q <= 1'b1;
              end
            end else begin
              bit_q    <= bit_q + 3'd1;
              tx_out_q <= shift_q[1];
            end
          end
        end
        PARITY: begin
          if (bit_end_d) begin
            state_q  <= STOP;
            tx_out_q <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end_d) begin
            // A pending byte starts its start bit on this same edge: no idle gap.
            if (stop_load_d) begin
              state_q  <= START;
              tx_out_q <= 1'b0;
              busy_q   <= 1'b1;
              shift_q  <= src_data_d;
              par_q    <= parity_f(src_data_d, src_par_typ_d);
              par_en_q <= src_par_en_d;
              pre_q    <= src_pre_d;
            end else begin
              state_q  <= IDLE;
              tx_out_q <= 1'b1;
              busy_q   <= 1'b0;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          tx_out_q <= 1'b1;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: scoreboard of expected frames checked cycle by cycle on the line.
module tb_uart_tx_serializer;

  logic       clk_RX;
  logic       rst;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       tx_ready;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] prescale;
  logic       TX_OUT;
  logic       busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] data;
    logic       par_en;
    logic       par_typ;
    logic [5:0] pre;
  } frame_t;

  frame_t exp_q[$];

  uart_tx_serializer dut (
    .clk_RX     (clk_RX),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .tx_ready   (tx_ready),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .prescale   (prescale),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  initial clk_RX = 1'b0;
  always #5 clk_RX = ~clk_RX;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  function automatic logic model_bit(input frame_t f, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return f.data[b-1];
    if ((b == 9) && f.par_en) return (^f.data) ^ f.par_typ;
    return 1'b1;
  endfunction

  // Present a byte one cycle, expect acceptance, and record the expected frame.
  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] pre, input string tag);
    frame_t f;
    @(negedge clk_RX);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; prescale = pre; data_valid = 1'b1;
    total++;
    if (tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready: tx_ready=%b, required 1", tag, tx_ready);
    end
    @(posedge clk_RX);
    #1;
    data_valid = 1'b0;
    f.data = d; f.par_en = pe; f.par_typ = pt; f.pre = pre;
    exp_q.push_back(f);
  endtask

  // Pop one expected frame and check every cycle of every bit on TX_OUT and busy.
  task automatic check_frame(input string tag);
    frame_t f;
    int p, nbits, nbad;
    logic exp_b, act_b, act_busy;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s_sb: scoreboard empty, required one pending frame", tag);
      return;
    end
    f = exp_q.pop_front();
    p = (f.pre < 6'd4) ? 4 : int'(f.pre);
    nbits = f.par_en ? 11 : 10;
    for (int b = 0; b < nbits; b++) begin
      exp_b = model_bit(f, b);
      nbad = 0; act_b = exp_b; act_busy = 1'b1;
      for (int c = 0; c < p; c++) begin
        @(negedge clk_RX);
        if ((TX_OUT !== exp_b) || (busy !== 1'b1)) begin
          nbad++; act_b = TX_OUT; act_busy = busy;
        end
      end
      total++;
      if (nbad != 0) begin
        bad++;
        $display("FAIL %s_bit%0d: TX_OUT=%b busy=%b in %0d of %0d cycles, required TX_OUT=%b busy=1",
                 tag, b, act_b, act_busy, nbad, p, exp_b);
      end
    end
  endtask

  // Line must stay idle (high, not busy, ready) for n cycles.
  task automatic check_idle(input string tag, input int n);
    int nbad;
    logic a_tx, a_busy, a_rdy;
    nbad = 0; a_tx = 1'b1; a_busy = 1'b0; a_rdy = 1'b1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk_RX);
      if ((TX_OUT !== 1'b1) || (busy !== 1'b0) || (tx_ready !== 1'b1)) begin
        nbad++; a_tx = TX_OUT; a_busy = busy; a_rdy = tx_ready;
      end
    end
    total++;
    if (nbad != 0) begin
      bad++;
      $display("FAIL %s_idle: TX_OUT=%b busy=%b tx_ready=%b in %0d cycles, required 1/0/1", tag, a_tx, a_busy, a_rdy, nbad);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_RX);
    total++;
    if ((TX_OUT !== 1'b1) || (busy !== 1'b0) || (tx_ready !== 1'b1)) begin
      bad++;
      $display("FAIL reset_values: TX_OUT=%b busy=%b tx_ready=%b, required 1/0/1", TX_OUT, busy, tx_ready);
    end
    rst = 1'b1;
    check_idle("post_reset", 4);
  endtask

  task automatic test_basic();
    send(8'hA5, 1'b0, 1'b0, 6'd8, "basic");
    check_frame("basic_a5");
    check_idle("basic_end", 3);
  endtask

  task automatic test_parity();
    send(8'h07, 1'b1, 1'b0, 6'd16, "par_even");
    check_frame("par_even");
    check_idle("par_even_end", 2);
    send(8'h07, 1'b1, 1'b1, 6'd16, "par_odd");
    check_frame("par_odd");
    check_idle("par_odd_end", 2);
  endtask

  task automatic test_midframe_change();
    send(8'h3C, 1'b0, 1'b0, 6'd8, "mid");
    P_DATA = 8'hFF; PAR_EN = 1'b1; PAR_TYP = 1'b1; prescale = 6'd20;
    check_frame("mid_3c");
    check_idle("mid_end", 3);
  endtask

`ifdef UART_TX_HOLD_BUF_EN
  task automatic test_back_to_back();
    int n;
    send(8'h11, 1'b0, 1'b0, 6'd8, "b2b_first");
    fork
      begin
        check_frame("b2b_11");
        check_frame("b2b_22");
      end
      begin
        repeat (3) @(negedge clk_RX);
        send(8'h22, 1'b0, 1'b0, 6'd8, "b2b_second");
        n = 0;
        @(negedge clk_RX);
        while ((tx_ready !== 1'b1) && (n < 200)) begin
          n++;
          @(negedge clk_RX);
        end
        total++;
        if (n != 76) begin
          bad++;
          $display("FAIL b2b_ready_low: tx_ready low for %0d cycles, required 76", n);
        end
      end
    join
    check_idle("b2b_end", 3);
  endtask
`else
  task automatic test_ignore_busy();
    send(8'h11, 1'b0, 1'b0, 6'd8, "ign");
    fork
      check_frame("ign_11");
      begin
        repeat (4) @(negedge clk_RX);
        P_DATA = 8'h22; data_valid = 1'b1;
        total++;
        if (tx_ready !== 1'b0) begin
          bad++;
          $display("FAIL ign_ready: tx_ready=%b while busy, required 0", tx_ready);
        end
        repeat (20) @(negedge clk_RX);
        data_valid = 1'b0;
      end
    join
    check_idle("ign_end", 20);
  endtask
`endif

  task automatic test_reset_midframe();
    send(8'h5A, 1'b0, 1'b0, 6'd8, "rstmid");
    repeat (30) @(negedge clk_RX);
    rst = 1'b0;
    #1;
    total++;
    if ((TX_OUT !== 1'b1) || (busy !== 1'b0) || (tx_ready !== 1'b1)) begin
      bad++;
      $display("FAIL rstmid_async: TX_OUT=%b busy=%b tx_ready=%b, required 1/0/1", TX_OUT, busy, tx_ready);
    end
    void'(exp_q.pop_front());
    @(negedge clk_RX);
    rst = 1'b1;
    check_idle("rstmid_release", 3);
    send(8'hC3, 1'b1, 1'b1, 6'd8, "rstmid_next");
    check_frame("rstmid_c3");
    check_idle("rstmid_end", 3);
  endtask

  task automatic test_min_prescale();
    send(8'h96, 1'b0, 1'b0, 6'd2, "pre2");
    check_frame("pre2_96");
    check_idle("pre2_end", 2);
    send(8'h81, 1'b1, 1'b0, 6'd3, "pre3");
    check_frame("pre3_81");
    check_idle("pre3_end", 2);
  endtask

  initial begin
    rst = 1'b0;
    P_DATA = 8'h00; data_valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 6'd8;
    test_reset();
    test_basic();
    test_parity();
    test_midframe_change();
`ifdef UART_TX_HOLD_BUF_EN
    test_back_to_back();
`else
    test_ignore_busy();
`endif
    test_reset_midframe();
    test_min_prescale();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
